// File: rtl/ccr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ccr_ctrl_pkg
// Shared definitions for the condition-code register controller:
//   - ALU operation codes seen in the EX stage
//   - bit positions of the {C,N,Z} flags inside a 3-bit flag vector
//   - condition codes of a taken jump
// ---------------------------------------------------------------------------
package ccr_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_SETC = 4'b0001;
    localparam logic [3:0] OP_CLRC = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_IN   = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    // Flag bit indices within {C,N,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;

    // Kind of taken jump
    typedef enum logic [1:0] {
        JC_JMP = 2'b00,
        JC_JZ  = 2'b01,
        JC_JN  = 2'b10,
        JC_JC  = 2'b11
    } jmp_cond_e;

endpackage : ccr_ctrl_pkg

// File: rtl/ccr_ctrl_stack.sv
// ---------------------------------------------------------------------------
// ccr_stack
// DEPTH x 3-bit LIFO holding saved condition codes across nested interrupts.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears the count only)
//   i_push      : push i_din (ignored when full)
//   i_pop       : pop the top entry (ignored when empty); wins over i_push
//   i_din       : data to push
//   o_top       : current top entry (meaningless when empty)
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
// ---------------------------------------------------------------------------
module ccr_stack
    import ccr_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [2:0] i_din,
    output logic [2:0] o_top,
    output logic       o_full,
    output logic       o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [2:0]    r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == CW'(0));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !o_full && !w_do_pop;
    assign w_top_idx = r_count - CW'(1);
    assign o_top     = r_mem[w_top_idx[IW-1:0]];

    // Entry count; contents need no reset because the count gates every read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= CW'(0);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Storage write at the first free slot.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_count[IW-1:0]] <= i_din;
        end
    end

endmodule : ccr_stack

// File: rtl/ccr_ctrl.sv
// ---------------------------------------------------------------------------
// ccr_ctrl
// Condition-code register controller. Owns the architectural {C,N,Z} flags,
// commits ALU flags per EX opcode, clears the flag consumed by a taken
// conditional jump, and saves/restores flags on interrupt entry / RTI.
// Optional feature macro: CCR_FWD_EN (adds ccr_fwd, the next-edge ccr value).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ex_valid     : EX holds a real instruction
//   alu_op       : EX opcode
//   alu_flags    : ALU flags {C,N,Z}
//   jmp_taken    : taken jump this cycle
//   jmp_cond     : 00 JMP, 01 JZ, 10 JN, 11 JC
//   int_save     : push flags (interrupt entry)
//   rti_restore  : pop flags (RTI)
//   ccr_fwd      : (CCR_FWD_EN only) value ccr takes at the next edge
//   ccr          : registered flags {C,N,Z}
//   stack_empty  : no saved entries
//   stack_full   : DEPTH saved entries
//   ovf_err      : sticky stack misuse error
// ---------------------------------------------------------------------------
module ccr_ctrl
    import ccr_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic [3:0] alu_op,
    input  logic [2:0] alu_flags,
    input  logic       jmp_taken,
    input  logic [1:0] jmp_cond,
    input  logic       int_save,
    input  logic       rti_restore,
`ifdef CCR_FWD_EN
    output logic [2:0] ccr_fwd,
`else
`endif
    output logic [2:0] ccr,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       ovf_err
);

    logic [2:0] r_ccr;
    logic       r_ovf_err;
    logic [2:0] w_ex;
    logic [2:0] w_upd;
    logic [2:0] w_next;
    logic [2:0] w_top;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_err;

    // EX-stage flag commit selected by opcode.
    always_comb begin
        w_ex = r_ccr;
        if (ex_valid) begin
            case (alu_op)
                OP_SETC: w_ex[FLG_C] = 1'b1;
                OP_CLRC: w_ex[FLG_C] = 1'b0;
                OP_NOT, OP_DEC, OP_SUB, OP_AND, OP_OR: begin
                    w_ex[FLG_N] = alu_flags[FLG_N];
                    w_ex[FLG_Z] = alu_flags[FLG_Z];
                end
                OP_INC, OP_ADD, OP_SHL, OP_SHR: w_ex = alu_flags;
                default: w_ex = r_ccr;
            endcase
        end else begin
            w_ex = r_ccr;
        end
    end

    // Taken conditional jump consumes (clears) its flag after the EX commit.
    always_comb begin
        w_upd = w_ex;
        if (jmp_taken) begin
            case (jmp_cond)
                JC_JZ:   w_upd[FLG_Z] = 1'b0;
                JC_JN:   w_upd[FLG_N] = 1'b0;
                JC_JC:   w_upd[FLG_C] = 1'b0;
                default: w_upd = w_ex;
            endcase
        end else begin
            w_upd = w_ex;
        end
    end

    // Restore takes priority over save; a simultaneous request is an error.
    assign w_pop  = rti_restore && !w_empty;
    assign w_push = int_save && !rti_restore && !w_full;
    assign w_err  = (int_save && rti_restore) ||
                    (int_save && w_full) ||
                    (rti_restore && w_empty);
    assign w_next = w_pop ? w_top : w_upd;

    ccr_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_upd),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Architectural flag register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccr     <= 3'b000;
            r_ovf_err <= 1'b0;
        end else begin
            r_ccr     <= w_next;
            r_ovf_err <= r_ovf_err | w_err;
        end
    end

    assign ccr         = r_ccr;
    assign ovf_err     = r_ovf_err;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

`ifdef CCR_FWD_EN
    assign ccr_fwd = w_next;
`else
    // Without forwarding, consumers see only the registered ccr.
`endif

endmodule : ccr_ctrl

// File: tb/tb_ccr_ctrl.sv
// Scoreboard bench for ccr_ctrl: the driver computes the expected state from a
// behavioural flag/stack model and queues it; the monitor compares after each edge.
module tb_ccr_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [3:0] alu_op;
    logic [2:0] alu_flags;
    logic       jmp_taken;
    logic [1:0] jmp_cond;
    logic       int_save;
    logic       rti_restore;
    logic [2:0] ccr;
    logic       stack_empty;
    logic       stack_full;
    logic       ovf_err;
`ifdef CCR_FWD_EN
    logic [2:0] ccr_fwd;
`endif

    ccr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .alu_op      (alu_op),
        .alu_flags   (alu_flags),
        .jmp_taken   (jmp_taken),
        .jmp_cond    (jmp_cond),
        .int_save    (int_save),
        .rti_restore (rti_restore),
`ifdef CCR_FWD_EN
        .ccr_fwd     (ccr_fwd),
`endif
        .ccr         (ccr),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: flags as bits, saved flags in a queue used as a stack
    bit         m_c, m_n, m_z;
    bit         m_ovf;
    logic [2:0] m_stk [$];
    logic [5:0] exp_q [$];   // {ccr, empty, full, ovf}

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ccr=%b empty=%b full=%b ovf=%b, want ccr=%b empty=%b full=%b ovf=%b",
                     name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [5:0] model_state();
        return {m_c, m_n, m_z, (m_stk.size() == 0), (m_stk.size() == DEPTH), m_ovf};
    endfunction

    task automatic model_reset();
        m_c = 1'b0; m_n = 1'b0; m_z = 1'b0; m_ovf = 1'b0;
        m_stk.delete();
    endtask

    // One instruction cycle: drive at negedge, advance the model, queue expectation.
    task automatic cyc(input bit ev, input logic [3:0] op, input logic [2:0] fl,
                       input bit jt, input logic [1:0] jc, input bit is, input bit rr);
        bit c, n, z;
        @(negedge clk);
        ex_valid = ev; alu_op = op; alu_flags = fl;
        jmp_taken = jt; jmp_cond = jc; int_save = is; rti_restore = rr;
        c = m_c; n = m_n; z = m_z;
        if (ev) begin
            if (op == 4'd1) c = 1'b1;
            else if (op == 4'd2) c = 1'b0;
            else if (op inside {4'd4, 4'd6, 4'd9, 4'd10, 4'd11}) begin
                n = fl[1]; z = fl[0];
            end else if (op inside {4'd5, 4'd8, 4'd12, 4'd13}) begin
                c = fl[2]; n = fl[1]; z = fl[0];
            end
        end
        if (jt) begin
            if (jc == 2'd1) z = 1'b0;
            if (jc == 2'd2) n = 1'b0;
            if (jc == 2'd3) c = 1'b0;
        end
        if (rr) begin
            if (is) m_ovf = 1'b1;
            if (m_stk.size() > 0) begin
                {m_c, m_n, m_z} = m_stk.pop_back();
            end else begin
                {m_c, m_n, m_z} = {c, n, z};
                m_ovf = 1'b1;
            end
        end else if (is) begin
            if (m_stk.size() < DEPTH) m_stk.push_back({c, n, z});
            else m_ovf = 1'b1;
            {m_c, m_n, m_z} = {c, n, z};
        end else begin
            {m_c, m_n, m_z} = {c, n, z};
        end
        exp_q.push_back(model_state());
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT state shortly after every edge that has an expectation
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check6("cycle", {ccr, stack_empty, stack_full, ovf_err}, e);
            end
        end
    end

    initial begin
        ex_valid = 1'b0; alu_op = 4'd0; alu_flags = 3'd0; jmp_taken = 1'b0;
        jmp_cond = 2'd0; int_save = 1'b0; rti_restore = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #3;
        check6("reset", {ccr, stack_empty, stack_full, ovf_err}, 6'b000_1_0_0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flag commit
        cyc(1'b1, 4'b1000, 3'b101, 1'b0, 2'd0, 1'b0, 1'b0);   // ADD -> 101
        cyc(1'b1, 4'b1001, 3'b010, 1'b0, 2'd0, 1'b0, 1'b0);   // SUB -> 110
        cyc(1'b1, 4'b0010, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0);   // CLRC -> 010
        cyc(1'b0, 4'b0001, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0);   // bubble
        cyc(1'b1, 4'b0001, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0);   // SETC
        cyc(1'b1, 4'b0010, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0);   // CLRC
        cyc(1'b1, 4'b0111, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0);   // MOV no change

        // Jump clear
        cyc(1'b1, 4'b1000, 3'b011, 1'b0, 2'd0, 1'b0, 1'b0);   // 011
        cyc(1'b0, 4'b0000, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0);  // JZ -> 010
        cyc(1'b1, 4'b1000, 3'b011, 1'b0, 2'd0, 1'b0, 1'b0);   // 011
        cyc(1'b1, 4'b1010, 3'b001, 1'b1, 2'b01, 1'b0, 1'b0);  // AND + JZ -> 000
        cyc(1'b1, 4'b1000, 3'b111, 1'b1, 2'b00, 1'b0, 1'b0);  // JMP no clear

        // Save / restore
        cyc(1'b1, 4'b1000, 3'b110, 1'b0, 2'd0, 1'b0, 1'b0);   // 110
        cyc(1'b0, 4'b0000, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0);   // save 110
        cyc(1'b1, 4'b1000, 3'b001, 1'b0, 2'd0, 1'b0, 1'b0);   // 001
        cyc(1'b1, 4'b1000, 3'b111, 1'b0, 2'd0, 1'b0, 1'b1);   // restore 110

        // Fill beyond DEPTH with distinct values, then drain beyond empty
        for (int k = 1; k <= 5; k++)
            cyc(1'b1, 4'b1000, 3'(k), 1'b0, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            cyc(1'b1, 4'b0101, 3'b111, 1'b0, 2'd0, 1'b0, 1'b1);
        idle();

        // Asynchronous reset mid-operation with two saved entries
        cyc(1'b1, 4'b1000, 3'b101, 1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 4'b1000, 3'b011, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; int_save = 1'b0; rti_restore = 1'b0; jmp_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check6("async_reset", {ccr, stack_empty, stack_full, ovf_err}, 6'b000_1_0_0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            bit is, rr;
            r  = int'($urandom_range(0, 99));
            is = (r < 12);
            rr = (r >= 12 && r < 22) || (r == 99);
            if (r == 99) is = 1'b1;
            cyc(bit'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom),
                bit'($urandom_range(0, 2) == 0), 2'($urandom), is, rr);
        end

        // Drain the scoreboard with a bounded wait
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ccr_ctrl
